// File: rtl/apb_pkg.sv
// Shared definitions for the APB register-file responder.
//   apb_state_t : transfer FSM states (IDLE / WAIT / DONE)
//   REG_*       : fixed register indices inside the bank
//   APB_ADDR_W / APB_DATA_W : default bus widths
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 5;
  localparam int unsigned APB_DATA_W = 32;

  // Width of a register index (bank holds at most 8 slots).
  localparam int unsigned REG_IDX_W = 3;

  localparam logic [REG_IDX_W-1:0] REG_MASK   = 3'd5;
  localparam logic [REG_IDX_W-1:0] REG_STATUS = 3'd6;
  localparam logic [REG_IDX_W-1:0] REG_EVENT  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_wait_counter.sv
// Wait-state counter for the APB responder.
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   load     : load WAIT_STATES into the counter
//   dec      : decrement by one (holds at zero)
//   zero     : count is zero
module apb_wait_counter #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int unsigned CW = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_STATES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/apb_regfile_responder.sv
// APB completer serving a small register bank.
//   Map: 0..4 R/W scratch, 5 R/W irq mask, 6 read-only status_in,
//        7 event latch (set by event_in, write-1-to-clear, set wins).
// Ports:
//   pclk, rst          : clock, asynchronous active-high reset
//   psel, penable, pwrite, paddr, pwdata : APB request from the bridge
//   status_in          : live status, read at index 6
//   event_in           : single-cycle event pulses latched into index 7
//   prdata, pready, pslverr : APB response, nonzero only in the DONE cycle
//   irq                : registered |(reg7 & reg5)
// Build option: define APB_SLVERR_EN to answer out-of-range accesses and
// writes to index 6 with pslverr=1; otherwise they complete silently
// (write dropped, read returns 0).
module apb_regfile_responder
  import apb_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned ADDR_W      = APB_ADDR_W,
  parameter int unsigned DATA_W      = APB_DATA_W
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] status_in,
  input  logic [DATA_W-1:0] event_in,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              irq
);

  apb_state_t state;

  logic [DATA_W-1:0] regs [0:5];
  logic [DATA_W-1:0] ev_reg;

  logic                 cnt_zero;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic                 commit;
  logic                 addr_ok;
  logic                 bad;
  logic                 err_next;
  logic                 wr_en;
  logic [REG_IDX_W-1:0] idx;
  logic [DATA_W-1:0]    rd_val;
  logic [DATA_W-1:0]    rdata_next;
  logic [DATA_W-1:0]    ev_clr;

  apb_wait_counter #(
    .WAIT_STATES (WAIT_STATES)
  ) u_wait_counter (
    .clk  (pclk),
    .rst  (rst),
    .load (cnt_load),
    .dec  (cnt_dec),
    .zero (cnt_zero)
  );

  always_comb begin
    idx      = paddr[REG_IDX_W-1:0];
    addr_ok  = ({{(32-ADDR_W){1'b0}}, paddr} < NUM_REGS);
    bad      = !addr_ok || (pwrite && (idx == REG_STATUS));
    cnt_load = (state == IDLE) && psel && !penable;
    cnt_dec  = (state == WAIT) && psel && penable && !cnt_zero;
    commit   = (state == WAIT) && psel && penable && cnt_zero;
    wr_en    = commit && pwrite && !bad;

`ifdef APB_SLVERR_EN
    err_next = bad;
`else
    err_next = 1'b0;
`endif

    // Reads see pre-write register contents; the event latch also shows
    // pulses arriving on the same edge.
    rd_val = '0;
    if (addr_ok) begin
      if (idx == REG_STATUS)     rd_val = status_in;
      else if (idx == REG_EVENT) rd_val = ev_reg | event_in;
      else                       rd_val = regs[idx];
    end

    rdata_next = (commit && !pwrite && !err_next) ? rd_val : '0;
    ev_clr     = (wr_en && (idx == REG_EVENT)) ? pwdata : '0;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pready  <= 1'b0;
      prdata  <= '0;
      pslverr <= 1'b0;
      irq     <= 1'b0;
      ev_reg  <= '0;
      for (int unsigned i = 0; i < 6; i++) begin
        regs[i] <= '0;
      end
    end else begin
      // Response outputs are one-cycle pulses aligned with DONE.
      pready  <= commit;
      prdata  <= rdata_next;
      pslverr <= commit && err_next;
      irq     <= |(ev_reg & regs[REG_MASK]);

      // Clear first, then OR in new events so a same-cycle set wins.
      ev_reg <= (ev_reg & ~ev_clr) | event_in;

      if (wr_en && (idx < REG_STATUS)) begin
        regs[idx] <= pwdata;
      end

      case (state)
        IDLE: if (psel && !penable) state <= WAIT;
        WAIT: begin
          if (!psel)       state <= IDLE;
          else if (commit) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_regfile_responder.sv
module tb_apb_regfile_responder;

  localparam int WS = 1;
`ifdef APB_SLVERR_EN
  localparam logic SE = 1'b1;
`else
  localparam logic SE = 1'b0;
`endif

  logic        pclk;
  logic        rst;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [4:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] status_in;
  logic [31:0] event_in;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        irq;

  apb_regfile_responder #(
    .NUM_REGS    (8),
    .WAIT_STATES (WS),
    .ADDR_W      (5),
    .DATA_W      (32)
  ) dut (
    .pclk      (pclk),
    .rst       (rst),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .status_in (status_in),
    .event_in  (event_in),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .irq       (irq)
  );

  typedef struct {
    logic        rd;
    logic [31:0] data;
    logic        err;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per pready pulse; outside DONE the
  // response lines must be quiet.
  always @(negedge pclk) begin
    if (!rst) begin
      if (pready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pready: got pready=1 at cycle %0d expected no response", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL %s latency: got cycle %0d expected cycle %0d", e.name, cyc, e.cyc);
          end
          checks++;
          if (pslverr !== e.err) begin
            errors++;
            $display("FAIL %s pslverr: got %0b expected %0b", e.name, pslverr, e.err);
          end
          if (e.rd) begin
            checks++;
            if (prdata !== e.data) begin
              errors++;
              $display("FAIL %s prdata: got 0x%08h expected 0x%08h", e.name, prdata, e.data);
            end
          end
        end
      end else begin
        checks++;
        if ((prdata !== 32'h0) || (pslverr !== 1'b0)) begin
          errors++;
          $display("FAIL idle_outputs: got prdata=0x%08h pslverr=%0b expected 0/0 at cycle %0d",
                   prdata, pslverr, cyc);
        end
      end
    end
  end

  // Full transfer; ev is driven on event_in in the cycle before the commit edge.
  task automatic xfer(input string name, input logic wr, input logic [4:0] a,
                      input logic [31:0] d, input logic [31:0] exp_d,
                      input logic exp_err, input logic [31:0] ev);
    int   t;
    logic got;
    exp_t e;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    t = cyc;
    e.rd = !wr; e.data = exp_d; e.err = exp_err; e.cyc = t + 2 + WS; e.name = name;
    sb.push_back(e);
    @(posedge pclk); #1;
    penable  = 1'b1;
    event_in = (cyc == t + 1 + WS) ? ev : 32'h0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge pclk); #1;
      event_in = (cyc == t + 1 + WS) ? ev : 32'h0;
      if (pready) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no pready expected pready within 40 cycles", name);
    end
    psel = 1'b0; penable = 1'b0; event_in = 32'h0;
  endtask

  task automatic wr(input string name, input logic [4:0] a, input logic [31:0] d, input logic err);
    xfer(name, 1'b1, a, d, 32'h0, err, 32'h0);
  endtask

  task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp, input logic err);
    xfer(name, 1'b0, a, 32'h0, exp, err, 32'h0);
  endtask

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; status_in = '0; event_in = '0;
    repeat (3) @(posedge pclk);
    #1 rst = 1'b0;
    chk("reset_pready",  {31'h0, pready},  32'h0);
    chk("reset_prdata",  prdata,           32'h0);
    chk("reset_pslverr", {31'h0, pslverr}, 32'h0);
    chk("reset_irq",     {31'h0, irq},     32'h0);

    // Aborted write: psel drops during WAIT.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'd0; pwdata = 32'h55;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
    repeat (3) @(posedge pclk);
    rd("abort_rd0", 5'd0, 32'h0, 1'b0);
    wr("wr0", 5'd0, 32'h11, 1'b0);
    rd("rd0", 5'd0, 32'h11, 1'b0);

    wr("wr2", 5'd2, 32'hDEADBEEF, 1'b0);
    rd("rd2", 5'd2, 32'hDEADBEEF, 1'b0);

    status_in = 32'h12345678;
    rd("rd6", 5'd6, 32'h12345678, 1'b0);
    wr("wr6", 5'd6, 32'h0000AAAA, SE);
    rd("rd6_after_wr", 5'd6, 32'h12345678, 1'b0);

    wr("wr9", 5'd9, 32'h77, SE);
    rd("rd9", 5'd9, 32'h0, SE);
    rd("rd1_after_wr9", 5'd1, 32'h0, 1'b0);
    rd("rd0_after_wr9", 5'd0, 32'h11, 1'b0);
    rd("rd2_after_wr9", 5'd2, 32'hDEADBEEF, 1'b0);

    // Event latch and interrupt.
    @(posedge pclk); #1 event_in = 32'h5;
    @(posedge pclk); #1 event_in = 32'h0;
    rd("rd7_events", 5'd7, 32'h5, 1'b0);
    chk("irq_masked", {31'h0, irq}, 32'h0);
    wr("wr5", 5'd5, 32'h1, 1'b0);
    chk("irq_lag", {31'h0, irq}, 32'h0);
    @(posedge pclk); #1;
    chk("irq_set", {31'h0, irq}, 32'h1);
    rd("rd5", 5'd5, 32'h1, 1'b0);
    wr("w1c_bit0", 5'd7, 32'h1, 1'b0);
    @(posedge pclk); #1;
    chk("irq_cleared", {31'h0, irq}, 32'h0);
    rd("rd7_after_w1c", 5'd7, 32'h4, 1'b0);
    xfer("w1c_vs_set", 1'b1, 5'd7, 32'h4, 32'h0, 1'b0, 32'h4);
    rd("rd7_set_wins", 5'd7, 32'h4, 1'b0);
    xfer("rd7_same_edge_ev", 1'b0, 5'd7, 32'h0, 32'h14, 1'b0, 32'h10);
    rd("rd7_latched", 5'd7, 32'h14, 1'b0);
    wr("wr5_bit4", 5'd5, 32'h10, 1'b0);
    @(posedge pclk); #1;
    chk("irq_bit4", {31'h0, irq}, 32'h1);

    // Reset in the middle of a write.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'd1; pwdata = 32'hFF;
    @(posedge pclk); #1 penable = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_pready", {31'h0, pready}, 32'h0);
    chk("rst_mid_irq",    {31'h0, irq},    32'h0);
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1 rst = 1'b0;
    rd("post_rst_rd1", 5'd1, 32'h0, 1'b0);
    rd("post_rst_rd0", 5'd0, 32'h0, 1'b0);
    rd("post_rst_rd2", 5'd2, 32'h0, 1'b0);
    rd("post_rst_rd5", 5'd5, 32'h0, 1'b0);
    rd("post_rst_rd7", 5'd7, 32'h0, 1'b0);
    rd("post_rst_rd6", 5'd6, 32'h12345678, 1'b0);
    wr("wr4", 5'd4, 32'hCAFE0001, 1'b0);
    rd("rd4", 5'd4, 32'hCAFE0001, 1'b0);

    repeat (4) @(posedge pclk);
    #1;
    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
